// File: rtl/pb_pkg.sv
// Shared types and constants for the push-button event arbiter.
package pb_pkg;

    localparam int NUM_PB = 4;

    typedef enum logic {
        PB_IDLE   = 1'b0,
        PB_LOCKED = 1'b1
    } pb_state_t;

    typedef logic [1:0] pb_code_t;

    // Width of a counter able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/pb_event_fifo.sv
// Registered event FIFO; push while full is accepted only when a pop happens in the same cycle.
module pb_event_fifo
    import pb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  pb_code_t                    i_data,
    output pb_code_t                    o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    pb_code_t        r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_pop;
    logic            w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pb_event_arbiter.sv
// Push-button event arbiter: per-button lockout, fixed-priority enqueue, event FIFO.
// Optional auto-repeat on held buttons is enabled by defining PB_AUTO_REPEAT_EN.
module pb_event_arbiter
    import pb_pkg::*;
#(
    parameter int TICK_DIV        = 50000,
    parameter int LOCKOUT_MS      = 200,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_MS       = 100
) (
    input  logic                        Clock_50,
    input  logic                        Reset,
    input  logic [NUM_PB-1:0]           PB_pulse,
    input  logic [NUM_PB-1:0]           PB_level,
    output logic                        Event_valid,
    output pb_code_t                    Event_code,
    input  logic                        Event_ready,
    output logic [$clog2(FIFO_DEPTH):0] Event_count,
    output logic                        Overflow,
    input  logic                        Clear_overflow
);

    localparam int TW = cnt_width(TICK_DIV - 1);
    localparam int LW = cnt_width(LOCKOUT_MS);

    logic [TW-1:0]     r_tick_cnt;
    logic              w_tick;
    logic [NUM_PB-1:0] w_accept;
    logic [NUM_PB-1:0] w_set;
    logic [NUM_PB-1:0] r_pending;
    logic [NUM_PB-1:0] w_grant;
    logic [NUM_PB-1:0] w_drop;
    pb_code_t          w_grant_idx;
    logic              w_found;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge Clock_50) begin
        if (Reset || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    for (genvar g = 0; g < NUM_PB; g++) begin : g_pb
        pb_state_t     r_state;
        pb_state_t     w_state_nxt;
        logic [LW-1:0] r_lock_cnt;
        logic [LW-1:0] w_lock_nxt;

        assign w_accept[g] = PB_pulse[g] && (r_state == PB_IDLE);

        always_ff @(posedge Clock_50) begin
            if (Reset) begin
                r_state    <= PB_IDLE;
                r_lock_cnt <= '0;
            end else begin
                r_state    <= w_state_nxt;
                r_lock_cnt <= w_lock_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_lock_nxt  = r_lock_cnt;
            unique case (r_state)
                PB_IDLE: begin
                    if (PB_pulse[g] && (LOCKOUT_MS != 0)) begin
                        w_state_nxt = PB_LOCKED;
                        w_lock_nxt  = LW'(LOCKOUT_MS);
                    end
                end
                PB_LOCKED: begin
                    if (w_tick) begin
                        w_lock_nxt = r_lock_cnt - LW'(1);
                        if (r_lock_cnt == LW'(1)) begin
                            w_state_nxt = PB_IDLE;
                        end
                    end
                end
                default: w_state_nxt = PB_IDLE;
            endcase
        end

`ifdef PB_AUTO_REPEAT_EN
        localparam int RW = cnt_width((REPEAT_DELAY_MS > REPEAT_MS) ? REPEAT_DELAY_MS : REPEAT_MS);

        logic          r_hold_arm;
        logic [RW-1:0] r_hold_cnt;
        logic          w_repeat;

        // Down-counter: first expiry after the delay, then reloaded with the period.
        assign w_repeat = r_hold_arm && PB_level[g] && w_tick && (r_hold_cnt == RW'(1));

        always_ff @(posedge Clock_50) begin
            if (Reset || !PB_level[g]) begin
                r_hold_arm <= 1'b0;
                r_hold_cnt <= '0;
            end else if (w_accept[g]) begin
                r_hold_arm <= 1'b1;
                r_hold_cnt <= RW'(REPEAT_DELAY_MS);
            end else if (r_hold_arm && w_tick) begin
                if (r_hold_cnt == RW'(1)) begin
                    r_hold_cnt <= RW'(REPEAT_MS);
                end else begin
                    r_hold_cnt <= r_hold_cnt - RW'(1);
                end
            end
        end

        assign w_set[g] = w_accept[g] || w_repeat;
`else
        assign w_set[g] = w_accept[g];
`endif
    end

`ifndef PB_AUTO_REPEAT_EN
    logic w_unused_cfg;
    assign w_unused_cfg = (^PB_level) ^ (REPEAT_DELAY_MS != 0) ^ (REPEAT_MS != 0);
`endif

    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < NUM_PB; i++) begin
            if (r_pending[i] && !w_found) begin
                w_found     = 1'b1;
                w_grant[i]  = 1'b1;
                w_grant_idx = pb_code_t'(i);
            end
        end
    end

    assign w_pop  = Event_valid && Event_ready;
    assign w_push = w_found && (!w_full || w_pop);
    assign w_drop = w_set & r_pending;

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_pending <= '0;
            Overflow  <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~(w_push ? w_grant : '0)) | (w_set & ~r_pending);
            if (|w_drop) begin
                Overflow <= 1'b1;
            end else if (Clear_overflow) begin
                Overflow <= 1'b0;
            end
        end
    end

    pb_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Clock_50),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_grant_idx),
        .o_data  (Event_code),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (Event_count)
    );

    assign Event_valid = !w_empty;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Scoreboard bench for pb_event_arbiter; the held-button repeat scenario runs when PB_AUTO_REPEAT_EN is defined.
module tb_pb_event_arbiter;
    import pb_pkg::*;

    logic           Clock_50 = 1'b0;
    logic           Reset = 1'b1;
    logic [3:0]     PB_pulse = '0;
    logic [3:0]     PB_level = '0;
    logic           Event_valid;
    pb_code_t       Event_code;
    logic           Event_ready = 1'b0;
    logic [2:0]     Event_count;
    logic           Overflow;
    logic           Clear_overflow = 1'b0;

    int             checks = 0;
    int             errors = 0;
    pb_code_t       exp_q[$];
    pb_code_t       mon_exp;

    pb_event_arbiter #(
        .TICK_DIV        (4),
        .LOCKOUT_MS      (3),
        .FIFO_DEPTH      (4),
        .REPEAT_DELAY_MS (2),
        .REPEAT_MS       (1)
    ) dut (
        .Clock_50       (Clock_50),
        .Reset          (Reset),
        .PB_pulse       (PB_pulse),
        .PB_level       (PB_level),
        .Event_valid    (Event_valid),
        .Event_code     (Event_code),
        .Event_ready    (Event_ready),
        .Event_count    (Event_count),
        .Overflow       (Overflow),
        .Clear_overflow (Clear_overflow)
    );

    always #5 Clock_50 = ~Clock_50;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock_50);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        PB_pulse = b;
        step(1);
        PB_pulse = '0;
    endtask

    // Monitor: every accepted handshake must match the oldest expected code.
    always @(negedge Clock_50) begin
        if (!Reset && Event_valid && Event_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got code %0d expected none", Event_code);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event_code", int'(Event_code), int'(mon_exp));
            end
        end
    end

    initial begin
        int n;

        step(2);
        check("rst_valid", int'(Event_valid), 0);
        check("rst_code", int'(Event_code), 0);
        check("rst_count", int'(Event_count), 0);
        check("rst_overflow", int'(Overflow), 0);
        Reset = 1'b0;

        // Simultaneous presses drain lowest index first, one per cycle.
        Event_ready = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        press(4'b1011);
        check("sim_no_fallthrough", int'(Event_valid), 0);
        step(1);
        check("sim_c1_code", int'(Event_code), 0);
        check("sim_c1_count", int'(Event_count), 1);
        step(1);
        check("sim_c2_code", int'(Event_code), 1);
        check("sim_c2_count", int'(Event_count), 1);
        step(1);
        check("sim_c3_code", int'(Event_code), 3);
        check("sim_c3_count", int'(Event_count), 1);
        step(1);
        check("sim_done_valid", int'(Event_valid), 0);
        step(20);

        // Reset with three events queued discards them.
        Event_ready = 1'b0;
        press(4'b0111);
        step(3);
        check("pre_rst_count", int'(Event_count), 3);
        Reset = 1'b1;
        step(1);
        check("mid_rst_valid", int'(Event_valid), 0);
        check("mid_rst_count", int'(Event_count), 0);
        check("mid_rst_overflow", int'(Overflow), 0);
        Reset = 1'b0;
        press(4'b0100);
        check("post_rst_lat1", int'(Event_valid), 0);
        step(1);
        check("post_rst_valid", int'(Event_valid), 1);
        check("post_rst_code", int'(Event_code), 2);
        exp_q.push_back(2'd2);
        Event_ready = 1'b1;

        // Lockout: presses 5 and 8 cycles later are ignored, 20 cycles later accepted.
        exp_q.push_back(2'd1);
        press(4'b0010);
        step(4);
        press(4'b0010);
        step(2);
        press(4'b0010);
        step(4);
        check("lock_count", int'(Event_count), 0);
        check("lock_valid", int'(Event_valid), 0);
        check("lock_no_overflow", int'(Overflow), 0);
        step(7);
        exp_q.push_back(2'd1);
        press(4'b0010);
        step(1);
        check("unlock_valid", int'(Event_valid), 1);
        check("unlock_code", int'(Event_code), 1);
        step(20);

        // Fill the FIFO, hold one pending, overflow on a repeated press.
        Event_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pb_code_t'(i));
            press(4'(1 << i));
            step(1);
        end
        check("full_count", int'(Event_count), 4);
        check("full_head", int'(Event_code), 0);
        step(13);
        exp_q.push_back(2'd0);
        press(4'b0001);
        step(1);
        check("held_count", int'(Event_count), 4);
        check("held_overflow", int'(Overflow), 0);
        step(13);
        press(4'b0001);
        check("ovf_set", int'(Overflow), 1);
        Event_ready = 1'b1;
        step(1);
        check("push_pop_full_count", int'(Event_count), 4);
        step(1);
        check("drain_count", int'(Event_count), 3);
        n = 0;
        while (Event_count != 0 && n < 20) begin
            step(1);
            n++;
        end
        check("drain_done", int'(Event_count), 0);
        check("empty_code", int'(Event_code), 0);
        check("ovf_sticky", int'(Overflow), 1);
        Clear_overflow = 1'b1;
        step(1);
        Clear_overflow = 1'b0;
        check("ovf_cleared", int'(Overflow), 0);

`ifdef PB_AUTO_REPEAT_EN
        // Held button 3: first event plus repeats at ticks 2,3,..,7 after reset.
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        PB_level = 4'b1000;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(2'd3);
        end
        press(4'b1000);
        step(29);
        PB_level = '0;
        step(12);
        check("repeat_released_valid", int'(Event_valid), 0);
`endif

        step(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
